// File: rtl/door_controller.sv
`default_nettype none
// ============================================================================
// Module   : door_controller
// Purpose  : Moore FSM sequencing the elevator car door: open, dwell, close,
//            and reopen on obstruction. Also flags motor stroke faults.
// Revision : 1.0 - initial release
// ============================================================================
module door_controller #(
    parameter int W        = 10,
    parameter int T_ESPERA = 1000,
    parameter int T_MOTOR  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abrir,
    input  logic       cerrar,
    input  logic       obstaculo,
    input  logic       fin_abierta,
    input  logic       fin_cerrada,
    input  logic       movimiento,
    output logic [1:0] estado,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       puerta_cerrada,
    output logic       timeout,
    output logic       falla
);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        ABRIENDO = 2'b10,
        CERRANDO = 2'b11
    } state_t;

    localparam logic [W-1:0] c_ESPERA_LAST = W'(T_ESPERA - 1);
    localparam logic [W-1:0] c_MOTOR_LAST  = W'(T_MOTOR - 1);

    state_t         r_estado;
    state_t         w_next;
    logic [W-1:0]   r_cnt;
    logic           r_timeout;
    logic           r_falla;
    logic           w_restart;
    logic           w_timeout;
    logic           w_fault;

    always_comb begin
        w_next    = r_estado;
        w_restart = 1'b0;
        w_timeout = 1'b0;
        w_fault   = 1'b0;
        case (r_estado)
            CERRADA: begin
                if (abrir && !movimiento) w_next = ABRIENDO;
            end
            ABRIENDO: begin
                if (fin_abierta) begin
                    w_next = ABIERTA;
                end else if (r_cnt == c_MOTOR_LAST) begin
                    w_next  = ABIERTA;
                    w_fault = 1'b1;
                end
            end
            ABIERTA: begin
                // A new request or an obstruction keeps the door open and restarts the dwell
                if (abrir || obstaculo) begin
                    w_restart = 1'b1;
                end else if (cerrar) begin
                    w_next = CERRANDO;
                end else if (r_cnt == c_ESPERA_LAST) begin
                    w_next    = CERRANDO;
                    w_timeout = 1'b1;
                end
            end
            CERRANDO: begin
                if (obstaculo || abrir) begin
                    w_next = ABRIENDO;
                end else if (fin_cerrada) begin
                    w_next = CERRADA;
                end else if (r_cnt == c_MOTOR_LAST) begin
                    w_next  = ABRIENDO;
                    w_fault = 1'b1;
                end
            end
            default: w_next = CERRADA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado  <= CERRADA;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_falla   <= 1'b0;
        end else begin
            r_estado  <= w_next;
            r_timeout <= w_timeout;
            if (w_fault) r_falla <= 1'b1;
            if ((w_next != r_estado) || w_restart) begin
                r_cnt <= '0;
            end else if (r_cnt != {W{1'b1}}) begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign estado         = r_estado;
    assign motor_abrir    = (r_estado == ABRIENDO);
    assign motor_cerrar   = (r_estado == CERRANDO);
    assign puerta_cerrada = (r_estado == CERRADA) && fin_cerrada;
    assign timeout        = r_timeout;
    assign falla          = r_falla;

endmodule
`default_nettype wire

// File: tb/tb_door_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_door_controller
// Purpose  : Directed plus randomized bench for door_controller against an
//            elapsed-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_door_controller;

    localparam int TE = 8;
    localparam int TM = 5;

    logic       clk = 1'b0;
    logic       rst_n, abrir, cerrar, obstaculo, fin_abierta, fin_cerrada, movimiento;
    logic [1:0] estado;
    logic       motor_abrir, motor_cerrar, puerta_cerrada, timeout, falla;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: door phase (spec codes), edge index when the current
    // stroke/dwell started, sticky fault, and timeout pulse.
    int m_st    = 0;
    int m_since = 0;
    bit m_falla = 1'b0;
    bit m_tmo   = 1'b0;

    always #5 clk = ~clk;

    door_controller #(.W(10), .T_ESPERA(TE), .T_MOTOR(TM)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .abrir          (abrir),
        .cerrar         (cerrar),
        .obstaculo      (obstaculo),
        .fin_abierta    (fin_abierta),
        .fin_cerrada    (fin_cerrada),
        .movimiento     (movimiento),
        .estado         (estado),
        .motor_abrir    (motor_abrir),
        .motor_cerrar   (motor_cerrar),
        .puerta_cerrada (puerta_cerrada),
        .timeout        (timeout),
        .falla          (falla)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic go(input int st);
        m_st    = st;
        m_since = cyc + 1;
    endtask

    task automatic model_edge();
        int el;
        el    = cyc - m_since;
        m_tmo = 1'b0;
        if (!rst_n) begin
            go(0);
            m_falla = 1'b0;
        end else begin
            case (m_st)
                0: if (abrir && !movimiento) go(2);
                2: begin
                    if (fin_abierta) go(1);
                    else if (el >= TM - 1) begin go(1); m_falla = 1'b1; end
                end
                1: begin
                    if (abrir || obstaculo) m_since = cyc + 1;
                    else if (cerrar) go(3);
                    else if (el >= TE - 1) begin go(3); m_tmo = 1'b1; end
                end
                default: begin
                    if (obstaculo || abrir) go(2);
                    else if (fin_cerrada) go(0);
                    else if (el >= TM - 1) begin go(2); m_falla = 1'b1; end
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("estado", 32'(estado), 32'(m_st));
        chk("motor_abrir", 32'(motor_abrir), 32'(m_st == 2));
        chk("motor_cerrar", 32'(motor_cerrar), 32'(m_st == 3));
        chk("puerta_cerrada", 32'(puerta_cerrada), 32'((m_st == 0) && fin_cerrada));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("falla", 32'(falla), 32'(m_falla));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        abrir = 0; cerrar = 0; obstaculo = 0;
        fin_abierta = 0; fin_cerrada = 0; movimiento = 0;
    endtask

    task automatic wait_leave_open(output int n);
        n = 0;
        while (estado == 2'b01 && n < 50) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        idle_inputs();
        step(); step();
        rst_n = 1'b1;
        chk("reset_estado", 32'(estado), 32'd0);
        chk("reset_falla", 32'(falla), 32'd0);

        // Normal open / dwell / auto-close / closed
        abrir = 1; step(); abrir = 0;
        chk("t1_abriendo", 32'(estado), 32'd2);
        chk("t1_motor_abrir", 32'(motor_abrir), 32'd1);
        step();
        fin_abierta = 1; step(); fin_abierta = 0;
        chk("t1_abierta", 32'(estado), 32'd1);
        wait_leave_open(n);
        chk("t1_dwell_len", 32'(n), 32'd8);
        chk("t1_timeout", 32'(timeout), 32'd1);
        chk("t1_motor_cerrar", 32'(motor_cerrar), 32'd1);
        fin_cerrada = 1; step();
        chk("t1_cerrada", 32'(estado), 32'd0);
        chk("t1_puerta_cerrada", 32'(puerta_cerrada), 32'd1);
        fin_cerrada = 0;

        // Obstruction restarts the dwell
        abrir = 1; step(); abrir = 0;
        fin_abierta = 1; step(); fin_abierta = 0;
        repeat (6) step();
        obstaculo = 1; step(); obstaculo = 0;
        wait_leave_open(n);
        chk("t2_dwell_restart", 32'(n), 32'd8);

        // Reopen beats fully-closed in the same cycle
        obstaculo = 1; fin_cerrada = 1; step();
        obstaculo = 0; fin_cerrada = 0;
        chk("t3_reopen", 32'(estado), 32'd2);
        chk("t3_motor_cerrar", 32'(motor_cerrar), 32'd0);
        chk("t3_motor_abrir", 32'(motor_abrir), 32'd1);

        // Opening inhibited while moving, not latched
        fin_abierta = 1; step(); fin_abierta = 0;
        cerrar = 1; step(); cerrar = 0;
        fin_cerrada = 1; step();
        movimiento = 1; abrir = 1;
        repeat (3) step();
        chk("t4_inhibit", 32'(estado), 32'd0);
        abrir = 0; movimiento = 0;
        step(); step();
        chk("t4_not_latched", 32'(estado), 32'd0);
        fin_cerrada = 0;

        // Opening stroke times out; fault is sticky
        abrir = 1; step(); abrir = 0;
        repeat (5) step();
        chk("t5_fault_open", 32'(estado), 32'd1);
        chk("t5_falla", 32'(falla), 32'd1);
        wait_leave_open(n);
        fin_cerrada = 1; step(); fin_cerrada = 0;
        abrir = 1; step(); abrir = 0;
        fin_abierta = 1; step(); fin_abierta = 0;
        chk("t5_falla_sticky", 32'(falla), 32'd1);

        // Early close, then reset during closing
        step(); step();
        cerrar = 1; step(); cerrar = 0;
        chk("t6_early_close", 32'(estado), 32'd3);
        chk("t6_no_timeout", 32'(timeout), 32'd0);
        rst_n = 0; step(); rst_n = 1;
        chk("t6_reset_estado", 32'(estado), 32'd0);
        chk("t6_reset_motor", 32'(motor_cerrar), 32'd0);
        chk("t6_reset_falla", 32'(falla), 32'd0);

        // Randomized traffic with limit switches loosely following the motor
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom % 200) != 0;
            abrir       = ($urandom % 10) == 0;
            cerrar      = ($urandom % 12) == 0;
            obstaculo   = ($urandom % 15) == 0;
            movimiento  = ($urandom % 4) == 0;
            fin_abierta = (m_st == 2) ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
            fin_cerrada = (m_st == 3) ? (($urandom % 3) == 0) : (($urandom % 5) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
